dmem_initiator: RTL and testbench

DMEM_INITIATOR -- requirements
Module: dmem_initiator

---
 rtl/dmem_init_pkg.sv | 57 +++++
 rtl/dmem_itf.sv | 13 +
 rtl/dmem_req_fifo.sv | 47 ++++
 rtl/dmem_initiator.sv | 124 ++++++++++++
 tb/tb_dmem_initiator.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_init_pkg.sv
// Shared types for the data-memory initiator: funct3 codes, issue FSM states,
// request queue entry and the byte-lane helpers used on issue and completion.
package dmem_init_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Queue entries carry the tag at this width; the top truncates to TAG_W.
  localparam int unsigned TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [31:0]          addr;
    logic                 we;
    logic [2:0]           funct3;
    logic [31:0]          wdata;
    logic [TAG_MAX_W-1:0] tag;
  } req_entry_t;

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rdata,
                                              input logic [1:0] off);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {off, 3'b000};
    case (f3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_BU:   r = {24'h000000, s[7:0]};
      F3_HU:   r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || (f3[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_itf.sv
// Word-wide data-memory bus: initiator drives address, byte masks and write
// data; the target answers with rdata and a single-cycle resp.
interface dmem_itf;
  logic [31:0] addr;
  logic [3:0]  rmask;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        resp;

  modport mst (output addr, rmask, wmask, wdata, input rdata, resp);
  modport slv (input addr, rmask, wmask, wdata, output rdata, resp);
endinterface

// File: rtl/dmem_req_fifo.sv
// Request queue for dmem_initiator: DEPTH entries (power of two), head is
// presented combinationally; pushes when full and pops when empty are dropped.
module dmem_req_fifo
  import dmem_init_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = req_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dmem_initiator.sv
// In-order data-memory initiator: queues load/store requests, issues them one
// at a time on dmem_itf and returns tagged, extended completions.
// Optional: define DMEM_MISALIGN_CHK_EN to complete misaligned half/word ops with resp_err.
module dmem_initiator
  import dmem_init_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  dmem_itf.mst             mst_itf
);

  state_t     state;
  state_t     state_next;
  req_entry_t push_entry;
  req_entry_t head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       misalign;
  logic [3:0] issue_mask;

  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign push_entry = '{addr: req_addr, we: req_we, funct3: req_funct3,
                        wdata: req_wdata, tag: TAG_MAX_W'(req_tag)};
  assign issue_mask = byte_mask(head.funct3, head.addr[1:0]);

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = is_misaligned(head.funct3, head.addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  dmem_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Address/data follow the head from ISSUE until the pop; masks pulse in ISSUE only.
  always_comb begin
    state_next      = state;
    pop             = 1'b0;
    mst_itf.addr    = '0;
    mst_itf.wdata   = '0;
    mst_itf.rmask   = '0;
    mst_itf.wmask   = '0;
    if (state != IDLE) begin
      mst_itf.addr  = {head.addr[31:2], 2'b00};
      mst_itf.wdata = head.wdata << {head.addr[1:0], 3'b000};
    end
    case (state)
      IDLE: if (!empty) state_next = ISSUE;
      ISSUE: begin
        if (misalign) begin
          pop        = 1'b1;
          state_next = IDLE;
        end else begin
          if (head.we) mst_itf.wmask = issue_mask;
          else         mst_itf.rmask = issue_mask;
          if (mst_itf.resp) begin
            pop        = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mst_itf.resp) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= pop;
      if (pop) begin
        resp_tag  <= TAG_W'(head.tag);
        resp_data <= (head.we || misalign) ? '0
                   : load_extend(head.funct3, mst_itf.rdata, head.addr[1:0]);
        resp_err  <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed self-checking bench for dmem_initiator: a vector table of single
// transactions plus hand-written fill, early-resp, reset and misalignment sequences.
module tb_dmem_initiator;
  import dmem_init_pkg::*;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             resp_err;

  dmem_itf itf ();

  dmem_initiator #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_tag   (resp_tag),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mst_itf    (itf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_rmask;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [TAG_W-1:0] tag);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_tag    = tag;
    chk("push_ready", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ((itf.rmask | itf.wmask) != 4'b0000) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    n_total++;
    $display("FAIL wait_issue: no mask within 16 cycles, got 0 required nonzero");
  endtask

  // Waits for ISSUE, answers one cycle later, leaves outputs in the resp_valid cycle.
  task automatic serve(input logic [31:0] rdata, output bit ok);
    wait_issue(ok);
    if (!ok) return;
    step();
    itf.resp  = 1'b1;
    itf.rdata = rdata;
    step();
    itf.resp  = 1'b0;
    itf.rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input logic [TAG_W-1:0] tag);
    bit ok;
    push_req(v.we, v.f3, v.addr, v.wdata, tag);
    wait_issue(ok);
    if (!ok) return;
    chk("vec_addr",  itf.addr,  v.exp_addr);
    chk("vec_rmask", {28'b0, itf.rmask}, {28'b0, v.exp_rmask});
    chk("vec_wmask", {28'b0, itf.wmask}, {28'b0, v.exp_wmask});
    chk("vec_wdata", itf.wdata, v.exp_wdata);
    step();
    chk("vec_mask_wait", {24'b0, itf.rmask, itf.wmask}, 32'd0);
    chk("vec_addr_hold", itf.addr, v.exp_addr);
    itf.resp  = 1'b1;
    itf.rdata = v.rdata;
    step();
    itf.resp  = 1'b0;
    itf.rdata = '0;
    chk("vec_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("vec_resp_tag",   {28'b0, resp_tag}, {28'b0, tag});
    chk("vec_resp_data",  resp_data, v.exp_data);
    chk("vec_resp_err",   {31'b0, resp_err}, 32'd0);
    step();
    chk("vec_valid_pulse", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;

    vt[0] = '{1'b0, F3_W,  32'h1ECF1004, 32'h0,        32'hDEADBEEF, 32'h1ECF1004, 4'hF, 4'h0, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1'b0, F3_B,  32'h1ECF1003, 32'h0,        32'h80FFFFFF, 32'h1ECF1000, 4'h8, 4'h0, 32'h0,        32'hFFFFFF80};
    vt[2] = '{1'b0, F3_BU, 32'h1ECF1003, 32'h0,        32'h80FFFFFF, 32'h1ECF1000, 4'h8, 4'h0, 32'h0,        32'h00000080};
    vt[3] = '{1'b1, F3_H,  32'h00001002, 32'h00001234, 32'h5555AAAA, 32'h00001000, 4'h0, 4'hC, 32'h12340000, 32'h0};
    vt[4] = '{1'b0, F3_H,  32'h00000002, 32'h0,        32'h80010000, 32'h00000000, 4'hC, 4'h0, 32'h0,        32'hFFFF8001};
    vt[5] = '{1'b0, F3_HU, 32'h00000000, 32'h0,        32'h1234F00D, 32'h00000000, 4'h3, 4'h0, 32'h0,        32'h0000F00D};
    vt[6] = '{1'b1, F3_B,  32'h00000005, 32'h000000AB, 32'hFFFFFFFF, 32'h00000004, 4'h0, 4'h2, 32'h0000AB00, 32'h0};
    vt[7] = '{1'b1, F3_W,  32'h00000008, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h00000008, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0};
    vt[8] = '{1'b0, F3_B,  32'h00000001, 32'h0,        32'h00007F00, 32'h00000000, 4'h2, 4'h0, 32'h0,        32'h0000007F};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_tag    = '0;
    itf.resp   = 1'b0;
    itf.rdata  = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready",      {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_masks",      {24'b0, itf.rmask, itf.wmask}, 32'd0);
    chk("rst_addr",       itf.addr, 32'd0);
    chk("rst_wdata",      itf.wdata, 32'd0);
    chk("rst_resp_tag",   {28'b0, resp_tag}, 32'd0);
    chk("rst_resp_data",  resp_data, 32'd0);
    chk("rst_resp_err",   {31'b0, resp_err}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vt[i], TAG_W'(i + 1));

    // resp already high: ignored while idle, completes directly from ISSUE
    itf.resp  = 1'b1;
    itf.rdata = 32'h000000C3;
    step();
    step();
    chk("stray_idle", {31'b0, resp_valid}, 32'd0);
    push_req(1'b0, F3_BU, 32'h00000010, 32'h0, 4'd5);
    chk("early_no_pulse", {31'b0, resp_valid}, 32'd0);
    step();
    chk("early_rmask", {28'b0, itf.rmask}, 32'h1);
    step();
    itf.resp = 1'b0;
    chk("early_valid", {31'b0, resp_valid}, 32'd1);
    chk("early_tag",   {28'b0, resp_tag}, 32'd5);
    chk("early_data",  resp_data, 32'h000000C3);
    chk("early_idle_mask", {28'b0, itf.rmask}, 32'd0);
    step();
    chk("early_pulse", {31'b0, resp_valid}, 32'd0);

    // five pushes into a four-deep queue with the target stalled
    for (int i = 0; i < 4; i++) push_req(1'b0, F3_W, 32'(i * 4), 32'h0, TAG_W'(i + 1));
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h00000010;
    req_tag    = 4'd5;
    chk("fill_full", {31'b0, req_ready}, 32'd0);
    itf.resp  = 1'b1;
    itf.rdata = 32'h00000101;
    step();
    itf.resp = 1'b0;
    chk("fill_first_valid", {31'b0, resp_valid}, 32'd1);
    chk("fill_first_tag",   {28'b0, resp_tag}, 32'd1);
    chk("fill_ready_again", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      serve(32'(i), ok);
      if (ok) begin
        chk("fill_valid", {31'b0, resp_valid}, 32'd1);
        chk("fill_tag",   {28'b0, resp_tag}, 32'(i));
      end
    end

    // reset while an access is outstanding
    push_req(1'b0, F3_W, 32'h00000020, 32'h0, 4'hA);
    wait_issue(ok);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstw_addr",  itf.addr, 32'd0);
    itf.resp  = 1'b1;
    itf.rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstw_no_pulse", {31'b0, resp_valid}, 32'd0);
      chk("rstw_masks",    {24'b0, itf.rmask, itf.wmask}, 32'd0);
      chk("rstw_ready",    {31'b0, req_ready}, 32'd1);
    end
    itf.resp = 1'b0;
    push_req(1'b0, F3_W, 32'h00000024, 32'h0, 4'hB);
    serve(32'h11112222, ok);
    if (ok) begin
      chk("rstw_next_tag",  {28'b0, resp_tag}, 32'hB);
      chk("rstw_next_data", resp_data, 32'h11112222);
    end

`ifdef DMEM_MISALIGN_CHK_EN
    push_req(1'b0, F3_W, 32'h00000002, 32'h0, 4'd7);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      chk("mis_no_mask", {24'b0, itf.rmask, itf.wmask}, 32'd0);
      if (resp_valid) ok = 1'b1;
      else step();
    end
    chk("mis_valid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err",   {31'b0, resp_err}, 32'd1);
    chk("mis_data",  resp_data, 32'd0);
    chk("mis_tag",   {28'b0, resp_tag}, 32'd7);
`else
    push_req(1'b0, F3_W, 32'h00000002, 32'h0, 4'd7);
    wait_issue(ok);
    if (ok) begin
      chk("mis_rmask", {28'b0, itf.rmask}, 32'hF);
      chk("mis_addr",  itf.addr, 32'd0);
      step();
      itf.resp  = 1'b1;
      itf.rdata = 32'hAABBCCDD;
      step();
      itf.resp = 1'b0;
      chk("mis_valid", {31'b0, resp_valid}, 32'd1);
      chk("mis_err",   {31'b0, resp_err}, 32'd0);
      chk("mis_data",  resp_data, 32'h0000AABB);
      chk("mis_tag",   {28'b0, resp_tag}, 32'd7);
    end
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
